grid_row_loader: RTL and testbench
==================================

Name: grid_row_loader

Overview:
Loads the initial Game-of-Life grid into the active grid BRAM before generation starts. Software delivers the grid as a stream of 32-bit words, 40 words per 1280-cell row, through the AXI-Lite register file. This block assembles each row and issues one full-width BRAM write per row, for rows 0..719. It sits upstream of the mode selector's BRAM write path, and its load_done output gates the start of next-state calculation and video readout.

Parameters:
X_SIZE, 1280, cells per row (BRAM data width)
Y_SIZE, 720, rows per grid (BRAM depth)
WORD_W, 32, bits per input word; X_SIZE must be an integer multiple of WORD_W
(localparams) WORDS_PER_ROW = X_SIZE/WORD_W = 40; Y_WIDTH = clog2(Y_SIZE) = 10; WCNT_W = clog2(WORDS_PER_ROW) = 6

Ports:
out_stream_aclk  in  1  clock; all logic is on the rising edge
periph_resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins (or restarts) a grid load
word_data  in  WORD_W  grid word; bit 31 is the leftmost cell of the 32-cell group
word_valid  in  1  word_data is valid
word_ready  out  1  block accepts a word this cycle
bram_addr  out  Y_WIDTH  BRAM row address
bram_din  out  X_SIZE  row data to BRAM; bit 1279 is column 0
bram_we  out  1  BRAM write strobe, high for exactly one cycle per row
busy  out  1  a load is in progress (state COLLECT or WRITE)
load_done  out  1  level: full grid written; held until the next start
row_count  out  Y_WIDTH  number of rows committed in the current load

Behaviour:
- Reset: asynchronous, active-low. On reset, state=IDLE; row buffer, word counter and row_idx are cleared; bram_we=0, bram_addr=0, bram_din=0, load_done=0, row_count=0. A reset during a load abandons it, and no further write is issued.
- States: IDLE, COLLECT, WRITE, DONE.
- word_ready = (state==COLLECT) && !start. Combinational; it is the only combinational output.
- IDLE: start -> COLLECT with row_idx=0, word_cnt=0, row_count=0. Words are not accepted.
- COLLECT: on word_valid && word_ready, row_buf <= {row_buf[X_SIZE-WORD_W-1:0], word_data} and word_cnt++. The first word therefore lands in bits 1279:1248. When the accepted word is the 40th (word_cnt==39), go to WRITE and clear word_cnt.
- WRITE: lasts exactly one cycle. bram_we, bram_addr=row_idx and bram_din=row_buf are registered and valid during this cycle. Latency: 40th handshake at edge N -> bram_we high for the cycle after N. row_count <= row_idx+1 on exit from WRITE.
  - If row_idx==Y_SIZE-1 -> DONE, with load_done<=1.
  - Otherwise row_idx++ and return to COLLECT.
- Throughput: minimum 41 cycles per row; word_valid may stall for any number of cycles.
- DONE: load_done=1, word_ready=0. start -> COLLECT as from IDLE, and load_done drops on the same edge.
- start in COLLECT: restart. The partial row is discarded, row_idx/word_cnt/row_count are cleared, and no word is accepted in that cycle.
- start in WRITE: ignored. The pending write completes; software must re-issue start.
- bram_addr and bram_din hold their last values when bram_we=0, so the bench must check them only while bram_we=1.
- The row counter never wraps: the DONE transition occurs at row_idx 719, and no address of 720 or above is ever driven.

Decomposition:
- Shared package (game-of-life constants): X_SIZE, Y_SIZE, X_WIDTH, Y_WIDTH, WORD_W, WORDS_PER_ROW, and the loader state encoding (IDLE=2'b00, COLLECT=2'b01, WRITE=2'b10, DONE=2'b11).
- One sub-module, row_assembler: the shift register plus word counter, with clear/shift_en inputs and row/row_full outputs. The top level holds the FSM, row_idx and the BRAM output registers.

Test Plan:
- Reset values: assert periph_resetn=0 mid-COLLECT (row 3, word 17) -> outputs return to reset values immediately. After release, no bram_we occurs until start followed by 40 words.
- Single-row ordering: start, then 40 words with word k = k+1 and no stalls -> bram_we is high one cycle after the 40th handshake. bram_addr=0, bram_din[1279:1248]=1, bram_din[31:0]=40, row_count=1.
- Full grid with random word_valid gaps:
  - 28800 words -> exactly 720 bram_we pulses at addresses 0..719 in order, each matching the scoreboard row.
  - load_done rises the cycle after the last write and word_ready=0 thereafter.
- Restart mid-row: start, 25 words, then start again with word_valid=1 in the same cycle -> that word is not accepted (word_ready=0). The next 40 words form row 0, with no data from the first 25 words.
- start during WRITE: pulse start coincident with bram_we for row 5 -> the write completes, row_idx advances to 6, and row_count=6.
- Reload after DONE: complete a load, then start with an all-ones grid -> load_done drops on the start edge, and the 720 rows are rewritten with bram_din all ones.

Source files
------------

// File: rtl/grid_row_loader_pkg.sv
// Game-of-Life grid constants and loader state encoding.
// Shared by the grid row loader and its row assembler.
package grid_row_loader_pkg;

  localparam int X_SIZE        = 1280;
  localparam int Y_SIZE        = 720;
  localparam int X_WIDTH       = $clog2(X_SIZE);
  localparam int Y_WIDTH       = $clog2(Y_SIZE);
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_ROW = X_SIZE / WORD_W;
  localparam int WCNT_W        = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_WRITE   = 2'b10,
    ST_DONE    = 2'b11
  } ld_state_t;

endpackage

// File: rtl/grid_row_loader_row_assembler.sv
// Shifts 32-bit words into a full grid row, first word leftmost.
// row already includes the word on the input, so it is final on the last shift.
module grid_row_loader_row_assembler
  import grid_row_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word,
  output logic [X_SIZE-1:0] row,
  output logic              row_full
);

  logic [X_SIZE-WORD_W-1:0] buf_q;
  logic [WCNT_W-1:0]        cnt;

  assign row      = {buf_q, word};
  assign row_full = (cnt == WCNT_W'(WORDS_PER_ROW - 1));

  // Hold the most recent words and count them within the row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt   <= '0;
    end else if (clear) begin
      buf_q <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      buf_q <= row[X_SIZE-WORD_W-1:0];
      cnt   <= row_full ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/grid_row_loader.sv
// Streams software words into full grid rows and writes one BRAM row each.
// load_done holds once all rows are written until the next start.
module grid_row_loader
  import grid_row_loader_pkg::*;
(
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic               start,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               word_valid,
  output logic               word_ready,
  output logic [Y_WIDTH-1:0] bram_addr,
  output logic [X_SIZE-1:0]  bram_din,
  output logic               bram_we,
  output logic               busy,
  output logic               load_done,
  output logic [Y_WIDTH-1:0] row_count
);

  ld_state_t          state;
  ld_state_t          state_nxt;
  logic [Y_WIDTH-1:0] row_idx;
  logic [X_SIZE-1:0]  row;
  logic               row_full;
  logic               restart;
  logic               accept;
  logic               last_row;

  assign accept   = word_valid && word_ready;
  assign last_row = (row_idx == Y_WIDTH'(Y_SIZE - 1));

  grid_row_loader_row_assembler u_asm (
    .clk      (out_stream_aclk),
    .rst_n    (periph_resetn),
    .clear    (restart),
    .shift_en (accept),
    .word     (word_data),
    .row      (row),
    .row_full (row_full)
  );

  // State register
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE,
      ST_DONE:    if (start) state_nxt = ST_COLLECT;
      ST_COLLECT: if (accept && row_full) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = last_row ? ST_DONE : ST_COLLECT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status decode; start is ignored while writing
  always_comb begin
    word_ready = 1'b0;
    busy       = 1'b0;
    restart    = 1'b0;
    unique case (state)
      ST_IDLE:    restart = start;
      ST_COLLECT: begin
        busy       = 1'b1;
        word_ready = !start;
        restart    = start;
      end
      ST_WRITE:   busy = 1'b1;
      ST_DONE:    restart = start;
      default:    ;
    endcase
  end

  // Row index, progress counters and registered BRAM port
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      row_idx   <= '0;
      row_count <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      load_done <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      if (restart) begin
        row_idx   <= '0;
        row_count <= '0;
        load_done <= 1'b0;
      end else if (accept && row_full) begin
        bram_we   <= 1'b1;
        bram_addr <= row_idx;
        bram_din  <= row;
      end else if (state == ST_WRITE) begin
        row_count <= row_idx + 1'b1;
        if (last_row) load_done <= 1'b1;
        else          row_idx   <= row_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grid_row_loader.sv
// Randomized self-checking bench for grid_row_loader.
// Expected rows are built by placing word k at bits 1279-32k downward.
module tb_grid_row_loader;

  localparam int X   = 1280;
  localparam int Y   = 720;
  localparam int WPR = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [9:0]    bram_addr;
  logic [X-1:0]  bram_din;
  logic          bram_we;
  logic          busy;
  logic          load_done;
  logic [9:0]    row_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]   a;
    logic [X-1:0] d;
  } wr_t;

  wr_t          wq[$];
  logic [X-1:0] exp_q[$];

  grid_row_loader dut (
    .out_stream_aclk (clk),
    .periph_resetn   (rst_n),
    .start           (start),
    .word_data       (word_data),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .bram_addr       (bram_addr),
    .bram_din        (bram_din),
    .bram_we         (bram_we),
    .busy            (busy),
    .load_done       (load_done),
    .row_count       (row_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bram_we) wq.push_back('{bram_addr, bram_din});

  task automatic send_word(input logic [31:0] w, input int gap);
    bit ok;
    ok = 1'b0;
    word_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    word_valid = 1'b1;
    word_data  = w;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = word_ready;
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_word: word_ready stayed %b, want 1", word_ready);
    end
  endtask

  task automatic send_row(input bit gaps, input bit ones,
                          output logic [X-1:0] row);
    logic [31:0] w;
    int          g;
    row = '0;
    for (int k = 0; k < WPR; k++) begin
      w = ones ? 32'hFFFF_FFFF : $urandom;
      row[X-1-32*k -: 32] = w;
      g = 0;
      if (gaps && $urandom_range(0, 7) == 0) g = int'($urandom_range(1, 2));
      send_word(w, g);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bram_we, busy, load_done, word_ready} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, want 0000",
               {bram_we, busy, load_done, word_ready});
    end
    tests++;
    if ({bram_addr, row_count} !== 20'd0) begin
      fails++;
      $display("FAIL reset_addr_cnt: got %0h/%0h, want 0/0",
               bram_addr, row_count);
    end
    tests++;
    if (bram_din !== '0) begin
      fails++;
      $display("FAIL reset_din: got nonzero, want 0");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_row();
    logic [X-1:0] r;
    wq.delete();
    pulse_start();
    tests++;
    if (busy !== 1'b1 || row_count !== 10'd0) begin
      fails++;
      $display("FAIL single_start: busy %b cnt %0d, want 1/0",
               busy, row_count);
    end
    r = '0;
    for (int k = 0; k < WPR; k++) begin
      r[X-1-32*k -: 32] = 32'(k + 1);
      send_word(32'(k + 1), 0);
    end
    @(negedge clk);
    tests++;
    if (bram_we !== 1'b1 || bram_addr !== 10'd0) begin
      fails++;
      $display("FAIL single_we: we %b addr %0d, want 1/0",
               bram_we, bram_addr);
    end
    tests++;
    if (bram_din[X-1 -: 32] !== 32'd1 || bram_din[31:0] !== 32'd40) begin
      fails++;
      $display("FAIL single_ends: got %0h/%0h, want 1/28",
               bram_din[X-1 -: 32], bram_din[31:0]);
    end
    tests++;
    if (bram_din !== r || word_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_row: din ok %b ready %b, want 1/0",
               bram_din === r, word_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bram_we !== 1'b0 || row_count !== 10'd1 || wq.size() != 1) begin
      fails++;
      $display("FAIL single_after: we %b cnt %0d writes %0d, want 0/1/1",
               bram_we, row_count, wq.size());
    end
  endtask

  task automatic test_reset_mid_collect();
    logic [X-1:0] r;
    pulse_start();
    for (int i = 0; i < 3; i++) send_row(1'b0, 1'b0, r);
    for (int k = 0; k < 17; k++) send_word($urandom, 0);
    tests++;
    if (row_count !== 10'd3 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: cnt %0d busy %b, want 3/1",
               row_count, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    wq.delete();
    tests++;
    if ({bram_we, busy, load_done, word_ready} !== 4'b0 ||
        {bram_addr, row_count} !== 20'd0 || bram_din !== '0) begin
      fails++;
      $display("FAIL midrst_out: flags %b addr %0d cnt %0d, want 0",
               {bram_we, busy, load_done, word_ready}, bram_addr,
               row_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      word_data = $urandom;
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
    tests++;
    if (wq.size() != 0 || word_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle: writes %0d ready %b, want 0/0",
               wq.size(), word_ready);
    end
    pulse_start();
    send_row(1'b1, 1'b0, r);
    @(negedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (wq.size() != 1 || wq[0].a !== 10'd0 || wq[0].d !== r) begin
      fails++;
      $display("FAIL midrst_row: writes %0d, want 1 at addr 0 matching",
               wq.size());
    end
  endtask

  task automatic test_restart();
    logic [X-1:0] r;
    pulse_start();
    for (int k = 0; k < 25; k++) send_word($urandom, 0);
    start      = 1'b1;
    word_valid = 1'b1;
    word_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if (word_ready !== 1'b0) begin
      fails++;
      $display("FAIL restart_ready: got %b, want 0", word_ready);
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    word_valid = 1'b0;
    wq.delete();
    send_row(1'b1, 1'b0, r);
    @(negedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (wq.size() != 1 || wq[0].a !== 10'd0 || wq[0].d !== r ||
        row_count !== 10'd1) begin
      fails++;
      $display("FAIL restart_row: writes %0d cnt %0d, want 1/1 matching",
               wq.size(), row_count);
    end
  endtask

  task automatic test_start_in_write();
    logic [X-1:0] r;
    pulse_start();
    for (int i = 0; i < 6; i++) send_row(1'b1, 1'b0, r);
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (bram_we !== 1'b1 || bram_addr !== 10'd5) begin
      fails++;
      $display("FAIL wrstart_we: we %b addr %0d, want 1/5",
               bram_we, bram_addr);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (row_count !== 10'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wrstart_cnt: cnt %0d busy %b, want 6/1",
               row_count, busy);
    end
    send_row(1'b1, 1'b0, r);
    @(negedge clk);
    tests++;
    if (bram_we !== 1'b1 || bram_addr !== 10'd6 || bram_din !== r) begin
      fails++;
      $display("FAIL wrstart_next: we %b addr %0d, want 1/6 matching",
               bram_we, bram_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_grid();
    logic [X-1:0] r;
    bit           bad;
    pulse_start();
    wq.delete();
    exp_q.delete();
    for (int i = 0; i < Y; i++) begin
      send_row(1'b1, 1'b0, r);
      exp_q.push_back(r);
    end
    @(negedge clk);
    tests++;
    if (bram_we !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL full_last: we %b done %b, want 1/0",
               bram_we, load_done);
    end
    @(posedge clk);
    #1;
    tests++;
    if (load_done !== 1'b1 || bram_we !== 1'b0) begin
      fails++;
      $display("FAIL full_done: done %b we %b, want 1/0",
               load_done, bram_we);
    end
    word_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (word_ready !== 1'b0) bad = 1'b1;
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    tests++;
    if (bad || wq.size() != Y) begin
      fails++;
      $display("FAIL full_count: writes %0d ready_seen %b, want 720/0",
               wq.size(), bad);
    end
    for (int i = 0; i < wq.size() && i < Y; i++) begin
      tests++;
      if (wq[i].a !== 10'(i) || wq[i].d !== exp_q[i]) begin
        fails++;
        $display("FAIL full_row: idx %0d addr %0d, want addr %0d match",
                 i, wq[i].a, i);
      end
    end
    tests++;
    if (row_count !== 10'd720 || busy !== 1'b0) begin
      fails++;
      $display("FAIL full_status: cnt %0d busy %b, want 720/0",
               row_count, busy);
    end
  endtask

  task automatic test_reload();
    logic [X-1:0] r;
    int           bad;
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (load_done !== 1'b1) begin
      fails++;
      $display("FAIL reload_pre: done %b, want 1", load_done);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (load_done !== 1'b0 || busy !== 1'b1 || row_count !== 10'd0) begin
      fails++;
      $display("FAIL reload_start: done %b busy %b cnt %0d, want 0/1/0",
               load_done, busy, row_count);
    end
    wq.delete();
    for (int i = 0; i < Y; i++) send_row(1'b0, 1'b1, r);
    @(negedge clk);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i].a !== 10'(i) || wq[i].d !== {X{1'b1}}) bad++;
    tests++;
    if (wq.size() != Y || bad != 0 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL reload_rows: writes %0d bad %0d done %b, want 720/0/1",
               wq.size(), bad, load_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_reset_mid_collect();
    test_restart();
    test_start_in_write();
    test_full_grid();
    test_reload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
